// File: rtl/z80_pkg.sv
// z80_pkg -- shared types for the Z80 control slice.
//   state_t    : controller FSM states (the encoding is visible on State_curr)
//   pc_sel_t   : PC_Select encodings
//   alu_op_t   : ALU_Select operation codes ({0, IR[5:3]} of the 0x80-0xBF group)
//   op_class_t : opcode classes produced by z80_decode
//   dest_t     : 8-bit load destinations (IR[5:3] of the 0x40-0x7F group)
//   pair_t     : 16-bit load targets (IR[5:4] of LD rr,nn)
package z80_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_ADDR = 3'd1,
    ST_FETCH_MEM  = 3'd2,
    ST_FETCH_IR   = 3'd3,
    ST_DECODE     = 3'd4,
    ST_OPERAND    = 3'd5,
    ST_EXECUTE    = 3'd6,
    ST_HALT       = 3'd7
  } state_t;

  // PC_PLUS4 is part of the encoding but nothing drives it in this revision.
  typedef enum logic [1:0] {
    PC_SEL_PLUS2 = 2'b00,
    PC_SEL_PLUS4 = 2'b01,
    PC_SEL_HOLD  = 2'b10
  } pc_sel_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_ADC = 4'd1,
    ALU_SUB = 4'd2,
    ALU_SBC = 4'd3,
    ALU_AND = 4'd4,
    ALU_XOR = 4'd5,
    ALU_OR  = 4'd6,
    ALU_CP  = 4'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_HALT = 3'd1,
    OP_LD16 = 3'd2,
    OP_LD8  = 3'd3,
    OP_ALU  = 3'd4
  } op_class_t;

  typedef enum logic [2:0] {
    DST_BC_H   = 3'd0,
    DST_BC_L   = 3'd1,
    DST_DE_H   = 3'd2,
    DST_DE_L   = 3'd3,
    DST_HL_H   = 3'd4,
    DST_HL_L   = 3'd5,
    DST_MEM_HL = 3'd6,
    DST_AF_H   = 3'd7
  } dest_t;

  typedef enum logic [1:0] {
    PAIR_BC = 2'd0,
    PAIR_DE = 2'd1,
    PAIR_HL = 2'd2,
    PAIR_SP = 2'd3
  } pair_t;

  // Width of the memory-wait counter; WAIT_MAX must fit in it.
  localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/z80_decode.sv
// z80_decode -- combinational opcode classifier.
//   ir       in  8 : current opcode
//   op_class out   : NOP / HALT / LD16 / LD8 / ALU
//   dest     out   : 8-bit load destination, IR[5:3]
//   pair     out   : 16-bit load target, IR[5:4]
// Build option: Z80_CTRL_ALU_EN enables the 0x80-0xBF ALU group; without it
// those opcodes fall through to NOP.
module z80_decode
  import z80_pkg::*;
(
  input  logic [7:0] ir,
  output op_class_t  op_class,
  output dest_t      dest,
  output pair_t      pair
);

  always_comb begin
    op_class = OP_NOP;
    if (ir == 8'h76) begin
      // 0x76 sits inside the LD r,r' block but is HALT.
      op_class = OP_HALT;
    end else if ((ir[7:6] == 2'b00) && (ir[3:0] == 4'h1)) begin
      op_class = OP_LD16;  // 0x01 / 0x11 / 0x21 / 0x31
    end else if (ir[7:6] == 2'b01) begin
      op_class = OP_LD8;
`ifdef Z80_CTRL_ALU_EN
    end else if (ir[7:6] == 2'b10) begin
      op_class = OP_ALU;
`endif
    end
  end

  assign dest = dest_t'(ir[5:3]);
  assign pair = pair_t'(ir[5:4]);

endmodule

// File: rtl/z80_control.sv
// z80_control -- instruction sequencing FSM for the Z80-style datapath.
//   Clk, Reset (async, active low), Run (stop at instruction boundary when low)
//   IR  : opcode; SP : reserved, unused in this revision
//   mem_resp : memory completed the current access
//   State_curr : FSM state; PC_Select, *_Load strobes, mux selects,
//   mem_read/mem_write/mem_byte_enable, ALU_Select : datapath controls
// Parameter WAIT_MAX: cycles allowed for mem_resp before HALT (0 = forever).
// Build option: Z80_CTRL_ALU_EN enables ALU execution (else ALU_Select = 0).
//
// Memory handshake: mem_read or mem_write is asserted in a waiting state and
// held unchanged until mem_resp is sampled high on a rising Clk edge, which
// completes the access and leaves the state. mem_resp seen in any other state
// has no effect. mem_read and mem_write are never asserted together.
module z80_control
  import z80_pkg::*;
#(
  parameter int WAIT_MAX = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic [7:0]  IR,
  input  logic [15:0] SP,
  input  logic        mem_resp,
  output logic [2:0]  State_curr,
  output logic [1:0]  PC_Select,
  output logic        PC_Load,
  output logic        IL_Load,
  output logic        MAL_Load,
  output logic        MDL_Load,
  output logic        SP_Load,
  output logic        MAR_Select,
  output logic        MDR_Select,
  output logic        Addr_Select,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [3:0]  ALU_Select,
  output logic        AF_Load,
  output logic        BC_Load,
  output logic        DE_Load,
  output logic        HL_Load,
  output logic        AF_H_Load,
  output logic        BC_H_Load,
  output logic        DE_H_Load,
  output logic        HL_H_Load,
  output logic        AF_L_Load,
  output logic        BC_L_Load,
  output logic        DE_L_Load,
  output logic        HL_L_Load
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_MAX - 1);

  state_t                  state, state_next;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  op_class_t               op_class;
  dest_t                   dest;
  pair_t                   pair;
  logic                    mem_dest;
  logic                    waiting;
  logic                    timeout;
  state_t                  done_state;
  logic                    sp_unused;

  assign sp_unused = ^SP;

  z80_decode u_decode (
    .ir       (IR),
    .op_class (op_class),
    .dest     (dest),
    .pair     (pair)
  );

  assign mem_dest   = (op_class == OP_LD8) && (dest == DST_MEM_HL);
  assign waiting    = (state == ST_FETCH_MEM) || (state == ST_OPERAND) ||
                      ((state == ST_EXECUTE) && mem_dest);
  // The cycle in which the counter holds WAIT_MAX-1 is the WAIT_MAX-th
  // waiting cycle; without a response there, give up.
  assign timeout    = (WAIT_MAX != 0) && waiting && !mem_resp &&
                      (wait_cnt == WAIT_LAST);
  assign done_state = Run ? ST_FETCH_ADDR : ST_IDLE;
  assign State_curr = state;

  // State register and wait counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (waiting && (state_next == state)) ?
                  wait_cnt + WAIT_CNT_W'(1) : '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (Run) state_next = ST_FETCH_ADDR;
      ST_FETCH_ADDR: state_next = ST_FETCH_MEM;
      ST_FETCH_MEM: begin
        if (mem_resp)     state_next = ST_FETCH_IR;
        else if (timeout) state_next = ST_HALT;
      end
      ST_FETCH_IR:   state_next = ST_DECODE;
      ST_DECODE: begin
        case (op_class)
          OP_HALT:        state_next = ST_HALT;
          OP_LD16:        state_next = ST_OPERAND;
          OP_LD8, OP_ALU: state_next = ST_EXECUTE;
          default:        state_next = done_state;
        endcase
      end
      ST_OPERAND: begin
        if (mem_resp)     state_next = ST_EXECUTE;
        else if (timeout) state_next = ST_HALT;
      end
      ST_EXECUTE: begin
        if (!mem_dest)    state_next = done_state;
        else if (mem_resp) state_next = done_state;
        else if (timeout) state_next = ST_HALT;
      end
      ST_HALT:       if (!Run) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    PC_Select       = PC_SEL_HOLD;
    PC_Load         = 1'b0;
    IL_Load         = 1'b0;
    MAL_Load        = 1'b0;
    MDL_Load        = 1'b0;
    SP_Load         = 1'b0;
    MAR_Select      = 1'b0;
    MDR_Select      = 1'b0;
    Addr_Select     = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    ALU_Select      = 4'd0;
    AF_Load         = 1'b0;
    BC_Load         = 1'b0;
    DE_Load         = 1'b0;
    HL_Load         = 1'b0;
    AF_H_Load       = 1'b0;
    BC_H_Load       = 1'b0;
    DE_H_Load       = 1'b0;
    HL_H_Load       = 1'b0;
    AF_L_Load       = 1'b0;
    BC_L_Load       = 1'b0;
    DE_L_Load       = 1'b0;
    HL_L_Load       = 1'b0;
    case (state)
      ST_FETCH_ADDR: MAL_Load = 1'b1;
      ST_FETCH_MEM: begin
        mem_read        = 1'b1;
        mem_byte_enable = 2'b11;
      end
      ST_FETCH_IR: begin
        IL_Load   = 1'b1;
        PC_Load   = 1'b1;
        PC_Select = PC_SEL_PLUS2;
      end
      ST_OPERAND: begin
        mem_read        = 1'b1;
        mem_byte_enable = 2'b11;
        // Operand lands in MDL and PC steps past it in the completing cycle.
        if (mem_resp) begin
          MDL_Load  = 1'b1;
          PC_Load   = 1'b1;
          PC_Select = PC_SEL_PLUS2;
        end
      end
      ST_EXECUTE: begin
        case (op_class)
          OP_LD16: begin
            case (pair)
              PAIR_BC: BC_Load = 1'b1;
              PAIR_DE: DE_Load = 1'b1;
              PAIR_HL: HL_Load = 1'b1;
              PAIR_SP: SP_Load = 1'b1;
              default: ;
            endcase
          end
          OP_LD8: begin
            case (dest)
              DST_BC_H: BC_H_Load = 1'b1;
              DST_BC_L: BC_L_Load = 1'b1;
              DST_DE_H: DE_H_Load = 1'b1;
              DST_DE_L: DE_L_Load = 1'b1;
              DST_HL_H: HL_H_Load = 1'b1;
              DST_HL_L: HL_L_Load = 1'b1;
              DST_AF_H: AF_H_Load = 1'b1;
              DST_MEM_HL: begin
                mem_write       = 1'b1;
                Addr_Select     = 1'b1;
                mem_byte_enable = 2'b01;
              end
              default: ;
            endcase
          end
`ifdef Z80_CTRL_ALU_EN
          OP_ALU: begin
            ALU_Select = {1'b0, dest};
            AF_H_Load  = 1'b1;
            AF_L_Load  = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_z80_control.sv
// tb_z80_control -- directed self-checking bench for z80_control (WAIT_MAX=4).
module tb_z80_control;

  logic        Clk, Reset, Run, mem_resp;
  logic [7:0]  IR;
  logic [15:0] SP;
  logic [2:0]  State_curr;
  logic [1:0]  PC_Select, mem_byte_enable;
  logic [3:0]  ALU_Select;
  logic PC_Load, IL_Load, MAL_Load, MDL_Load, SP_Load;
  logic MAR_Select, MDR_Select, Addr_Select, mem_read, mem_write;
  logic AF_Load, BC_Load, DE_Load, HL_Load;
  logic AF_H_Load, BC_H_Load, DE_H_Load, HL_H_Load;
  logic AF_L_Load, BC_L_Load, DE_L_Load, HL_L_Load;

  logic [21:0] strobes;
  logic [4:0]  ld16_vec;
  logic [7:0]  ld8_vec;

  int   n_checks = 0;
  int   n_fail = 0;
  int   pc_pulses = 0;
  int   wr_cycles = 0;
  logic rw_overlap = 1'b0;
  int   p0, w0;
  logic [2:0] exp_q[$];

  z80_control #(.WAIT_MAX(4)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .IR(IR), .SP(SP), .mem_resp(mem_resp),
    .State_curr(State_curr), .PC_Select(PC_Select), .PC_Load(PC_Load),
    .IL_Load(IL_Load), .MAL_Load(MAL_Load), .MDL_Load(MDL_Load), .SP_Load(SP_Load),
    .MAR_Select(MAR_Select), .MDR_Select(MDR_Select), .Addr_Select(Addr_Select),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .ALU_Select(ALU_Select), .AF_Load(AF_Load), .BC_Load(BC_Load),
    .DE_Load(DE_Load), .HL_Load(HL_Load), .AF_H_Load(AF_H_Load),
    .BC_H_Load(BC_H_Load), .DE_H_Load(DE_H_Load), .HL_H_Load(HL_H_Load),
    .AF_L_Load(AF_L_Load), .BC_L_Load(BC_L_Load), .DE_L_Load(DE_L_Load),
    .HL_L_Load(HL_L_Load)
  );

  assign strobes  = {PC_Load, IL_Load, MAL_Load, MDL_Load, SP_Load, mem_read,
                     mem_write, AF_Load, BC_Load, DE_Load, HL_Load, AF_H_Load,
                     BC_H_Load, DE_H_Load, HL_H_Load, AF_L_Load, BC_L_Load,
                     DE_L_Load, HL_L_Load, MAR_Select, MDR_Select, Addr_Select};
  assign ld16_vec = {AF_Load, BC_Load, DE_Load, HL_Load, SP_Load};
  assign ld8_vec  = {BC_H_Load, BC_L_Load, DE_H_Load, DE_L_Load,
                     HL_H_Load, HL_L_Load, AF_H_Load, AF_L_Load};

  // Clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Edge monitors: PC increments, (HL) write cycles, read/write overlap.
  always @(posedge Clk) begin
    if (PC_Load && (PC_Select == 2'b00)) pc_pulses <= pc_pulses + 1;
    if (mem_write && Addr_Select)        wr_cycles <= wr_cycles + 1;
    if (mem_read && mem_write)           rw_overlap <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic st(input string tag, input logic [2:0] s);
    chk(tag, 32'(State_curr), 32'(s));
  endtask

  // Driver: from FETCH_ADDR, fetch opcode op with mem_resp on the first
  // FETCH_MEM cycle; returns with the FSM in DECODE.
  task automatic fetch(input logic [7:0] op);
    IR = op;
    step; st("fetch_mem", 3'd2);
    mem_resp = 1'b1;
    step; st("fetch_ir", 3'd3);
    mem_resp = 1'b0;
    step; st("decode", 3'd4);
  endtask

  initial begin
    Reset = 1'b0; Run = 1'b0; IR = 8'h00; mem_resp = 1'b0; SP = 16'h1234;
    #1;
    st("reset_state", 3'd0);
    chk("reset_strobes", 32'(strobes), 32'd0);
    chk("reset_pcsel", 32'(PC_Select), 32'd2);
    chk("reset_mbe", 32'(mem_byte_enable), 32'd0);
    chk("reset_alu", 32'(ALU_Select), 32'd0);
    step; step;
    Reset = 1'b1;
    mem_resp = 1'b1;
    step; st("idle_hold", 3'd0);
    mem_resp = 1'b0;
    Run = 1'b1;

    // NOP with mem_resp one cycle after mem_read: 1,2,2,3,4,1
    p0 = pc_pulses;
    exp_q = {3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd1};
    for (int i = 0; i < 6; i++) begin
      step;
      mem_resp = (i == 2);
      chk("nop_seq", 32'(State_curr), 32'(exp_q.pop_front()));
      if (i == 0) chk("nop_mal", 32'(MAL_Load), 32'd1);
      if (i == 1) begin
        chk("nop_rd", 32'({mem_read, mem_write, Addr_Select}), 32'b100);
        chk("nop_mbe", 32'(mem_byte_enable), 32'd3);
        chk("nop_pcsel_hold", 32'(PC_Select), 32'd2);
      end
      if (i == 3) begin
        chk("nop_ir_load", 32'({IL_Load, PC_Load}), 32'b11);
        chk("nop_pcsel", 32'(PC_Select), 32'd0);
      end
    end
    chk("nop_pc_pulses", 32'(pc_pulses - p0), 32'd1);

    // NOP with Run dropped at the boundary -> IDLE
    fetch(8'h00);
    Run = 1'b0;
    step; st("nop_stop", 3'd0);
    Run = 1'b1;
    step; st("restart", 3'd1);

    // LD HL,nn with one extra operand wait cycle
    p0 = pc_pulses;
    fetch(8'h21);
    step; st("ld16_operand", 3'd5);
    chk("ld16_rd", 32'({mem_read, MDL_Load, PC_Load}), 32'b100);
    step; st("ld16_wait", 3'd5);
    mem_resp = 1'b1;
    #1;
    chk("ld16_resp", 32'({MDL_Load, PC_Load, PC_Select}), 32'b1100);
    step; mem_resp = 1'b0;
    st("ld16_exec", 3'd6);
    chk("ld16_hl", 32'(ld16_vec), 32'b00010);
    step; st("ld16_done", 3'd1);
    chk("ld16_clear", 32'(ld16_vec), 32'd0);
    chk("ld16_pc_pulses", 32'(pc_pulses - p0), 32'd2);

    // LD SP,nn
    fetch(8'h31);
    step; mem_resp = 1'b1;
    step; mem_resp = 1'b0;
    chk("ldsp_sp", 32'(ld16_vec), 32'b00001);
    step; st("ldsp_done", 3'd1);

    // LD B,C and LD A,B register destinations
    fetch(8'h41);
    step; chk("ld8_b", 32'({mem_write, ld8_vec}), 32'h080);
    step; st("ld8_b_done", 3'd1);
    fetch(8'h78);
    step; chk("ld8_a", 32'({mem_write, ld8_vec}), 32'h002);
    step; st("ld8_a_done", 3'd1);

    // LD (HL),B with mem_resp delayed 3 cycles
    w0 = wr_cycles;
    fetch(8'h70);
    step; st("ldm_exec", 3'd6);
    chk("ldm_wr", 32'({mem_write, mem_read, Addr_Select, mem_byte_enable, ld8_vec}),
        32'({5'b10101, 8'h00}));
    step; step; step;
    mem_resp = 1'b1;
    st("ldm_hold", 3'd6);
    step; mem_resp = 1'b0;
    st("ldm_done", 3'd1);
    chk("ldm_wr_cycles", 32'(wr_cycles - w0), 32'd4);

    // ALU group: SUB B
    fetch(8'h90);
`ifdef Z80_CTRL_ALU_EN
    step; st("alu_exec", 3'd6);
    chk("alu_sel", 32'(ALU_Select), 32'd2);
    chk("alu_af", 32'(ld8_vec), 32'h03);
    step; st("alu_done", 3'd1);
`else
    chk("alu_sel_tied", 32'(ALU_Select), 32'd0);
    step; st("alu_as_nop", 3'd1);
    chk("alu_no_load", 32'(ld8_vec), 32'd0);
`endif

    // HALT, stays with Run=1 (mem_resp ignored), leaves on Run=0
    fetch(8'h76);
    step; st("halt", 3'd7);
    chk("halt_strobes", 32'({strobes, PC_Select}), 32'(2'b10));
    mem_resp = 1'b1;
    step; step; st("halt_hold", 3'd7);
    mem_resp = 1'b0;
    Run = 1'b0;
    step; st("halt_exit", 3'd0);
    Run = 1'b1;
    step; st("halt_restart", 3'd1);

    // Fetch timeout: 4 cycles in FETCH_MEM then HALT
    IR = 8'h00;
    step; st("to_mem1", 3'd2);
    step; step; step; st("to_mem4", 3'd2);
    step; st("to_halt", 3'd7);
    Run = 1'b0;
    step; st("to_idle", 3'd0);

    // Reset asserted in the middle of a FETCH_MEM wait
    Run = 1'b1;
    step; step; step; st("rst_pre", 3'd2);
    Reset = 1'b0;
    #1;
    st("rst_mid_state", 3'd0);
    chk("rst_mid_strobes", 32'(strobes), 32'd0);
    chk("rst_mid_ctl", 32'({PC_Select, mem_byte_enable, ALU_Select}), 32'h80);
    step; st("rst_held", 3'd0);
    Reset = 1'b1;
    step; st("rst_first", 3'd1);
    step; step; step; step; st("rst_cnt_clear", 3'd2);
    step; st("rst_to_halt", 3'd7);

    chk("rd_wr_exclusive", 32'(rw_overlap), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
